// File: rtl/fir_tcdm_responder.sv
// fir_tcdm_responder: multi-port word-interleaved TCDM slave with per-bank round-robin arbitration
module fir_tcdm_responder #(
  parameter int          MP        = 4,
  parameter int          NB        = 8,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [MP-1:0]        tcdm_req_i,
  output logic [MP-1:0]        tcdm_gnt_o,
  input  logic [MP-1:0][31:0]  tcdm_add_i,
  input  logic [MP-1:0]        tcdm_wen_i,
  input  logic [MP-1:0][3:0]   tcdm_be_i,
  input  logic [MP-1:0][31:0]  tcdm_data_i,
  output logic [MP-1:0][31:0]  tcdm_r_data_o,
  output logic [MP-1:0]        tcdm_r_valid_o,
  input  logic [MP-1:0]        stall_i,
  output logic [31:0]          n_conflicts_o,
  output logic [15:0]          n_oor_o
);
  localparam int          PW   = MP > 1 ? $clog2(MP) : 1;
  localparam int          BW   = $clog2(NB);
  localparam int          AW   = $clog2(NB * DEPTH);
  localparam logic [31:0] SIZE = 32'(4 * NB * DEPTH);
  logic [MP-1:0]          elig, inr, win, denied, r_valid;
  logic [MP-1:0][31:0]    off;
  logic [MP-1:0][AW-1:0]  idx;
  logic [MP-1:0][BW-1:0]  bank;
  logic [NB-1:0][PW-1:0]  rr, win_idx;
  logic [NB-1:0]          win_v;
  logic [32:0]            conf_sum;
  logic [16:0]            oor_sum;
  logic [31:0]            mem [NB*DEPTH];
  // Address decode: flat word index w = row*NB + bank, so low bits select the bank
  always_comb begin
    off  = '0;
    inr  = '0;
    idx  = '0;
    bank = '0;
    for (int p = 0; p < MP; p++) begin
      off[p]  = tcdm_add_i[p] - BASE_ADDR;
      inr[p]  = tcdm_add_i[p] >= BASE_ADDR && off[p] < SIZE;
      idx[p]  = off[p][AW+1:2];
      bank[p] = idx[p][BW-1:0];
    end
  end
  assign elig = tcdm_req_i & ~stall_i;
  // Per-bank round-robin: first eligible in-range port from rr[b] upwards wins the bank
  always_comb begin
    win     = '0;
    win_v   = '0;
    win_idx = '0;
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < MP; k++) begin
        int q;
        q = (int'(rr[b]) + k) % MP;
        if (!win_v[b] && elig[q] && inr[q] && bank[q] == BW'(b)) begin
          win_v[b]   = 1'b1;
          win_idx[b] = PW'(q);
          win[q]     = 1'b1;
        end
      end
  end
  assign tcdm_gnt_o     = rst_i ? '0 : elig & (~inr | win);
  assign denied         = elig & inr & ~win;
  assign conf_sum       = {1'b0, n_conflicts_o} + 33'($countones(denied));
  assign oor_sum        = {1'b0, n_oor_o} + 17'($countones(tcdm_gnt_o & ~inr));
  assign tcdm_r_valid_o = r_valid & ~{MP{rst_i}};
  // Responses, round-robin pointers and saturating statistics
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid       <= '0;
      tcdm_r_data_o <= '0;
      rr            <= '0;
      n_conflicts_o <= '0;
      n_oor_o       <= '0;
    end else begin
      r_valid       <= tcdm_gnt_o;
      n_conflicts_o <= conf_sum[32] ? '1 : conf_sum[31:0];
      n_oor_o       <= oor_sum[16] ? '1 : oor_sum[15:0];
      for (int p = 0; p < MP; p++)
        if (tcdm_gnt_o[p] && tcdm_wen_i[p])
          tcdm_r_data_o[p] <= inr[p] ? mem[idx[p]] : 32'hDEAD_BEEF;
      for (int b = 0; b < NB; b++)
        if (win_v[b])
          rr[b] <= win_idx[b] == PW'(MP - 1) ? '0 : win_idx[b] + 1'b1;
    end
  end
  // Storage is never reset; at most one access per bank per cycle so writes never collide
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < MP; p++)
      for (int i = 0; i < 4; i++)
        if (tcdm_gnt_o[p] && !tcdm_wen_i[p] && inr[p] && tcdm_be_i[p][i])
          mem[idx[p]][8*i +: 8] <= tcdm_data_i[p][8*i +: 8];
  end
endmodule

// File: tb/tb_fir_tcdm_responder.sv
// tb_fir_tcdm_responder: directed self-checking bench for the TCDM responder
module tb_fir_tcdm_responder;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] SIZE = 32'h0000_8000;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req = '0, gnt, wen = '0, r_valid, stall = '0;
  logic [3:0][31:0] add = '0, data = '0, r_data;
  logic [3:0][3:0]  be = '0;
  logic [31:0]      n_conf;
  logic [15:0]      n_oor;
  int total = 0;
  int bad = 0;
  fir_tcdm_responder dut (
    .clk_i(clk), .rst_i(rst), .tcdm_req_i(req), .tcdm_gnt_o(gnt), .tcdm_add_i(add),
    .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(data), .tcdm_r_data_o(r_data),
    .tcdm_r_valid_o(r_valid), .stall_i(stall), .n_conflicts_o(n_conf), .n_oor_o(n_oor)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    req[p] = r; wen[p] = w; add[p] = a; be[p] = b; data[p] = d;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    for (int p = 0; p < 4; p++) drive(p, 1'b1, 1'b1, BASE, 4'hF, 32'h0);
    cyc(); cyc();
    total++; if (gnt !== 4'h0) begin bad++; $display("FAIL reset_gnt got=%h exp=0", gnt); end
    total++; if (r_valid !== 4'h0) begin bad++; $display("FAIL reset_rvalid got=%h exp=0", r_valid); end
    total++; if (r_data !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", r_data); end
    total++; if (n_conf !== 32'h0 || n_oor !== 16'h0) begin bad++; $display("FAIL reset_counters got=%h/%h exp=0/0", n_conf, n_oor); end
    req = '0;
    rst = 1'b0;
  endtask
  task automatic test_write_read();
    drive(0, 1'b1, 1'b0, BASE, 4'hF, 32'hCAFE_F00D);
    #1;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL wr_gnt got=%b exp=0001", gnt); end
    cyc();
    drive(0, 1'b1, 1'b1, BASE, 4'hF, 32'h0);
    total++; if (r_valid !== 4'b0001 || r_data[0] !== 32'h0) begin bad++; $display("FAIL wr_resp got=%b/%h exp=0001/0", r_valid, r_data[0]); end
    #1;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rd_gnt got=%b exp=0001", gnt); end
    cyc();
    req = '0;
    total++; if (r_valid !== 4'b0001 || r_data[0] !== 32'hCAFE_F00D) begin bad++; $display("FAIL rd_data got=%b/%h exp=0001/cafef00d", r_valid, r_data[0]); end
    cyc();
    total++; if (r_valid !== 4'b0000 || r_data[0] !== 32'hCAFE_F00D) begin bad++; $display("FAIL rd_hold got=%b/%h exp=0000/cafef00d", r_valid, r_data[0]); end
  endtask
  task automatic test_byte_enable();
    drive(0, 1'b1, 1'b0, BASE + 32'h40, 4'hF, 32'h1122_3344);
    cyc();
    drive(0, 1'b1, 1'b0, BASE + 32'h40, 4'b0101, 32'hAABB_CCDD);
    cyc();
    drive(0, 1'b1, 1'b1, BASE + 32'h40, 4'hF, 32'h0);
    cyc();
    req = '0;
    total++; if (r_data[0] !== 32'h11BB_33DD) begin bad++; $display("FAIL byte_en got=%h exp=11bb33dd", r_data[0]); end
  endtask
  task automatic test_conflict();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int p = 0; p < 4; p++) drive(p, 1'b1, 1'b1, BASE, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (gnt !== 4'(1 << i)) begin bad++; $display("FAIL conflict_gnt%0d got=%b exp=%b", i, gnt, 4'(1 << i)); end
      cyc();
      req[i] = 1'b0;
      total++; if (r_valid !== 4'(1 << i) || r_data[i] !== 32'hCAFE_F00D) begin bad++; $display("FAIL conflict_resp%0d got=%b/%h exp=%b/cafef00d", i, r_valid, r_data[i], 4'(1 << i)); end
    end
    total++; if (n_conf !== 32'd6) begin bad++; $display("FAIL conflict_count got=%0d exp=6", n_conf); end
  endtask
  task automatic test_back_to_back();
    for (int p = 0; p < 4; p++) drive(p, 1'b1, 1'b1, BASE + 32'(4 * p), 4'hF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (gnt !== 4'hF) begin bad++; $display("FAIL b2b_gnt%0d got=%b exp=1111", i, gnt); end
      cyc();
      total++; if (r_valid !== 4'hF) begin bad++; $display("FAIL b2b_rvalid%0d got=%b exp=1111", i, r_valid); end
    end
    req = '0;
    total++; if (n_conf !== 32'd6 || r_data[0] !== 32'hCAFE_F00D) begin bad++; $display("FAIL b2b_state got=%0d/%h exp=6/cafef00d", n_conf, r_data[0]); end
  endtask
  task automatic test_out_of_range();
    drive(1, 1'b1, 1'b1, BASE + SIZE, 4'hF, 32'h0);
    #1;
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL oor_gnt got=%b exp=0010", gnt); end
    cyc();
    total++; if (r_valid !== 4'b0010 || r_data[1] !== 32'hDEAD_BEEF || n_oor !== 16'd1) begin bad++; $display("FAIL oor_read got=%b/%h/%0d exp=0010/deadbeef/1", r_valid, r_data[1], n_oor); end
    drive(1, 1'b1, 1'b0, BASE + SIZE, 4'hF, 32'h0);
    cyc();
    total++; if (r_valid !== 4'b0010 || r_data[1] !== 32'hDEAD_BEEF || n_oor !== 16'd2) begin bad++; $display("FAIL oor_write got=%b/%h/%0d exp=0010/deadbeef/2", r_valid, r_data[1], n_oor); end
    drive(1, 1'b1, 1'b1, BASE - 32'd4, 4'hF, 32'h0);
    cyc();
    total++; if (r_data[1] !== 32'hDEAD_BEEF || n_oor !== 16'd3) begin bad++; $display("FAIL oor_below got=%h/%0d exp=deadbeef/3", r_data[1], n_oor); end
    drive(1, 1'b1, 1'b0, BASE + SIZE - 32'd4, 4'hF, 32'h5A5A_A5A5);
    cyc();
    drive(1, 1'b1, 1'b1, BASE + SIZE - 32'd4, 4'hF, 32'h0);
    cyc();
    total++; if (r_data[1] !== 32'h5A5A_A5A5 || n_oor !== 16'd3) begin bad++; $display("FAIL last_word got=%h/%0d exp=5a5aa5a5/3", r_data[1], n_oor); end
    req = '0;
    drive(0, 1'b1, 1'b1, BASE, 4'hF, 32'h0);
    cyc();
    req = '0;
    total++; if (r_data[0] !== 32'hCAFE_F00D) begin bad++; $display("FAIL oor_no_alias got=%h exp=cafef00d", r_data[0]); end
  endtask
  task automatic test_stall_reset();
    stall = 4'b0001;
    drive(0, 1'b1, 1'b1, BASE, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b1, BASE, 4'hF, 32'h0);
    #1;
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL stall_gnt got=%b exp=0010", gnt); end
    cyc();
    total++; if (r_valid !== 4'b0010 || n_conf !== 32'd6) begin bad++; $display("FAIL stall_count got=%b/%0d exp=0010/6", r_valid, n_conf); end
    stall = '0;
    req[1] = 1'b0;
    #1;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL unstall_gnt got=%b exp=0001", gnt); end
    cyc();
    rst = 1'b1;
    #1;
    total++; if (r_valid !== 4'h0 || gnt !== 4'h0) begin bad++; $display("FAIL rst_drop got=%b/%b exp=0000/0000", r_valid, gnt); end
    cyc();
    total++; if (r_valid !== 4'h0 || n_conf !== 32'h0 || n_oor !== 16'h0) begin bad++; $display("FAIL rst_clear got=%b/%0d/%0d exp=0/0/0", r_valid, n_conf, n_oor); end
    rst = 1'b0;
    cyc();
    req = '0;
    total++; if (r_valid !== 4'b0001 || r_data[0] !== 32'hCAFE_F00D) begin bad++; $display("FAIL rst_mem got=%b/%h exp=0001/cafef00d", r_valid, r_data[0]); end
  endtask
  initial begin
    #1;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_conflict();
    test_back_to_back();
    test_out_of_range();
    test_stall_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
